// File: rtl/win_line_buf.sv
// win_line_buf: ROWS x COLS pixel line buffer filled by streaming write beats,
// with a registered ROWS x WIN sliding-window read and a one-row scroll.
// Optional macro WIN_ZERO_PAD_EN: window columns left of column 0 read as zero;
// without it, column indices wrap modulo COLS.
module win_line_buf #(
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 16,
    parameter int unsigned WIN    = 4,
    parameter int unsigned WR_PIX = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_valid,
    output logic                            wr_ready,
    input  logic [WR_PIX*PIX_W-1:0]         wr_data,
    input  logic                            shift,
    input  logic                            rd_en,
    input  logic [$clog2(COLS)-1:0]         rd_col,
    output logic [ROWS*WIN*PIX_W-1:0]       rd_window,
    output logic                            rd_valid,
    output logic                            rd_err,
    output logic [$clog2(ROWS+1)-1:0]       rows_valid,
    output logic                            full
);

    localparam int unsigned CP_W     = $clog2(COLS);
    localparam int unsigned RV_W     = $clog2(ROWS + 1);
    localparam int unsigned RI_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned WIN_BITS = ROWS * WIN * PIX_W;

    logic [PIX_W-1:0]    mem_q [ROWS][COLS];

    logic [CP_W-1:0]     cp_q,          cp_d;
    logic [RV_W-1:0]     rows_valid_q,  rows_valid_d;
    logic                full_q,        full_d;
    logic                rd_valid_q,    rd_valid_d;
    logic                rd_err_q,      rd_err_d;
    logic [WIN_BITS-1:0] rd_window_q,   rd_window_d;

    logic                wr_fire;
    logic                shift_fire;
    logic [RI_W-1:0]     wr_row;
    logic [WIN_BITS-1:0] win_c;

    assign wr_fire    = wr_valid && !full_q;
    assign shift_fire = shift && full_q;
    assign wr_row     = RI_W'(rows_valid_q);

    // Fill tracking: column pointer, completed-row count and full flag.
    always_comb begin
        cp_d         = cp_q;
        rows_valid_d = rows_valid_q;
        if (wr_fire) begin
            cp_d = cp_q + CP_W'(WR_PIX);
            if (cp_d == '0) begin
                rows_valid_d = rows_valid_q + RV_W'(1);
            end
        end else if (shift_fire) begin
            rows_valid_d = RV_W'(ROWS - 1);
        end
        full_d = (rows_valid_d == RV_W'(ROWS));
    end

    // Window gather from the array: MSB is row 0 at its oldest column.
    always_comb begin
        logic [PIX_W-1:0] pix;
        int               idx;
        win_c = '0;
        pix   = '0;
        idx   = 0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            for (int unsigned j = 0; j < WIN; j++) begin
                idx = int'(rd_col) - int'(WIN) + 1 + int'(j);
`ifdef WIN_ZERO_PAD_EN
                if (idx < 0) begin
                    pix = '0;
                end else begin
                    pix = mem_q[r][CP_W'(idx)];
                end
`else
                pix = mem_q[r][CP_W'(idx)];
`endif
                win_c[(ROWS*WIN - 1 - (r*WIN + j))*PIX_W +: PIX_W] = pix;
            end
        end
    end

    // Read response: load window only when full, otherwise flag the rejection.
    always_comb begin
        rd_valid_d  = rd_valid_q;
        rd_err_d    = 1'b0;
        rd_window_d = rd_window_q;
        if (rd_en) begin
            rd_valid_d = full_q;
            rd_err_d   = !full_q;
            if (full_q) begin
                rd_window_d = win_c;
            end
        end else if (shift_fire) begin
            rd_valid_d = 1'b0;
        end
    end

    // Control and read-side registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cp_q         <= '0;
            rows_valid_q <= '0;
            full_q       <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
            rd_window_q  <= '0;
        end else begin
            cp_q         <= cp_d;
            rows_valid_q <= rows_valid_d;
            full_q       <= full_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
            rd_window_q  <= rd_window_d;
        end
    end

    // Pixel array: scroll rows up on shift, otherwise land an accepted beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (shift_fire) begin
                for (int unsigned r = 0; r + 1 < ROWS; r++) begin
                    mem_q[r] <= mem_q[r+1];
                end
            end else if (wr_fire) begin
                for (int unsigned c = 0; c < COLS; c++) begin
                    if (cp_q == CP_W'((c / WR_PIX) * WR_PIX)) begin
                        mem_q[wr_row][c] <= wr_data[(WR_PIX - 1 - (c % WR_PIX))*PIX_W +: PIX_W];
                    end
                end
            end
        end
    end

    assign wr_ready   = !full_q;
    assign full       = full_q;
    assign rows_valid = rows_valid_q;
    assign rd_valid   = rd_valid_q;
    assign rd_err     = rd_err_q;
    assign rd_window  = rd_window_q;

endmodule

// File: tb/tb_win_line_buf.sv
// tb_win_line_buf: directed bench for win_line_buf at default parameters.
module tb_win_line_buf;

    logic         clk;
    logic         rst;
    logic         wr_valid;
    logic         wr_ready;
    logic [31:0]  wr_data;
    logic         shift;
    logic         rd_en;
    logic [3:0]   rd_col;
    logic [127:0] rd_window;
    logic         rd_valid;
    logic         rd_err;
    logic [2:0]   rows_valid;
    logic         full;

    int n_checks;
    int n_fail;

    // Reference picture and fill position kept by the bench.
    logic [7:0]   ref_m [4][16];
    int           m_rows;
    int           m_cp;
    logic [127:0] exp_w;

    win_line_buf dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .shift      (shift),
        .rd_en      (rd_en),
        .rd_col     (rd_col),
        .rd_window  (rd_window),
        .rd_valid   (rd_valid),
        .rd_err     (rd_err),
        .rows_valid (rows_valid),
        .full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model_win(input int col);
        logic [127:0] w;
        int idx;
        w = '0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                idx = col - 3 + j;
`ifdef WIN_ZERO_PAD_EN
                if (idx < 0) w = {w[119:0], 8'h00};
                else         w = {w[119:0], ref_m[r][idx]};
`else
                w = {w[119:0], ref_m[r][(idx + 16) % 16]};
`endif
            end
        end
        return w;
    endfunction

    task automatic put_beat(input logic [31:0] d);
        logic acc;
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = d;
        acc      = wr_ready;
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
        if (acc) begin
            for (int k = 0; k < 4; k++) ref_m[m_rows][m_cp + k] = d[(3 - k)*8 +: 8];
            m_cp += 4;
            if (m_cp == 16) begin
                m_cp = 0;
                m_rows++;
            end
        end
    endtask

    task automatic fill_row(input logic [7:0] base);
        logic [31:0] d;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) d[(3 - k)*8 +: 8] = base + 8'(m_cp + k);
            put_beat(d);
        end
    endtask

    task automatic do_read(input int col, input logic sh);
        exp_w = model_win(col);
        @(negedge clk);
        rd_en  = 1'b1;
        rd_col = 4'(col);
        shift  = sh;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        shift = 1'b0;
        if (sh && m_rows == 4) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 16; c++) ref_m[r][c] = ref_m[r+1][c];
            m_rows = 3;
        end
    endtask

    task automatic shift_pulse();
        @(negedge clk);
        shift = 1'b1;
        @(posedge clk);
        #1;
        shift = 1'b0;
        if (m_rows == 4) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 16; c++) ref_m[r][c] = ref_m[r+1][c];
            m_rows = 3;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        m_rows = 0;
        m_cp   = 0;
    endtask

    initial begin
        logic [127:0] last_good;
        n_checks = 0;
        n_fail   = 0;
        m_rows   = 0;
        m_cp     = 0;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        shift    = 1'b0;
        rd_en    = 1'b0;
        rd_col   = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 16; c++) ref_m[r][c] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rows_valid", 128'(rows_valid), 128'd0);
        check("rst_full",       128'(full),       128'd0);
        check("rst_wr_ready",   128'(wr_ready),   128'd1);
        check("rst_rd_valid",   128'(rd_valid),   128'd0);
        check("rst_rd_err",     128'(rd_err),     128'd0);
        check("rst_rd_window",  rd_window,        128'd0);
        rst = 1'b0;

        // Fill with row*16+col; ready drops only after the 16th beat.
        fill_row(8'h00);
        fill_row(8'h10);
        fill_row(8'h20);
        check("fill3_rows_valid", 128'(rows_valid), 128'd3);
        check("fill3_wr_ready",   128'(wr_ready),   128'd1);
        fill_row(8'h30);
        check("fill4_wr_ready",   128'(wr_ready),   128'd0);
        check("fill4_full",       128'(full),       128'd1);
        check("fill4_rows_valid", 128'(rows_valid), 128'd4);
        put_beat(32'hFFFF_FFFF);
        check("beat17_rows_valid", 128'(rows_valid), 128'd4);
        check("beat17_full",       128'(full),       128'd1);

        // Read at column 7.
        do_read(7, 1'b0);
        check("rd7_valid",  128'(rd_valid), 128'd1);
        check("rd7_err",    128'(rd_err),   128'd0);
        check("rd7_window", rd_window, 128'h04050607_14151617_24252627_34353637);
        check("rd7_model",  rd_window, exp_w);

        // Left edge at column 1.
        do_read(1, 1'b0);
`ifdef WIN_ZERO_PAD_EN
        check("rd1_row0", 128'(rd_window[127:96]), 128'h00000001);
        check("rd1_row1", 128'(rd_window[95:64]),  128'h00001011);
`else
        check("rd1_row0", 128'(rd_window[127:96]), 128'h0E0F0001);
        check("rd1_row1", 128'(rd_window[95:64]),  128'h1E1F1011);
`endif
        check("rd1_model", rd_window, exp_w);

        // Shift with simultaneous read sees pre-shift rows.
        do_read(3, 1'b1);
        check("shrd_window",     rd_window, 128'h00010203_10111213_20212223_30313233);
        check("shrd_rows_valid", 128'(rows_valid), 128'd3);
        check("shrd_full",       128'(full),       128'd0);
        check("shrd_wr_ready",   128'(wr_ready),   128'd1);
        fill_row(8'h40);
        check("refill_full", 128'(full), 128'd1);
        do_read(3, 1'b0);
        check("refill_window", rd_window, 128'h10111213_20212223_30313233_40414243);
        check("refill_model",  rd_window, exp_w);
        last_good = exp_w;

        // Shift alone clears rd_valid.
        shift_pulse();
        check("shift_rd_valid",   128'(rd_valid),   128'd0);
        check("shift_rows_valid", 128'(rows_valid), 128'd3);

        // Read while not full: error pulse, window held.
        do_read(9, 1'b0);
        check("err3_rd_err",   128'(rd_err),   128'd1);
        check("err3_rd_valid", 128'(rd_valid), 128'd0);
        check("err3_window",   rd_window,      last_good);
        @(posedge clk);
        #1;
        check("err3_rd_err_drop", 128'(rd_err), 128'd0);

        // rows_valid == 2: error read, shift ignored.
        do_reset();
        fill_row(8'h50);
        fill_row(8'h60);
        check("two_rows_valid", 128'(rows_valid), 128'd2);
        do_read(5, 1'b0);
        check("err2_rd_err",   128'(rd_err),   128'd1);
        check("err2_rd_valid", 128'(rd_valid), 128'd0);
        check("err2_window",   rd_window,      128'd0);
        shift_pulse();
        check("err2_rd_err_drop",  128'(rd_err),     128'd0);
        check("ign_shift_rows",    128'(rows_valid), 128'd2);
        check("ign_shift_full",    128'(full),       128'd0);
        check("ign_shift_wr_ready",128'(wr_ready),   128'd1);

        // Reset after 6 beats discards fill state.
        do_reset();
        fill_row(8'h80);
        put_beat(32'h90919293);
        put_beat(32'h94959697);
        do_reset();
        check("mid_rst_rows_valid", 128'(rows_valid), 128'd0);
        check("mid_rst_full",       128'(full),       128'd0);
        check("mid_rst_rd_valid",   128'(rd_valid),   128'd0);
        fill_row(8'hA0);
        fill_row(8'hB0);
        fill_row(8'hC0);
        fill_row(8'hD0);
        check("fresh_full", 128'(full), 128'd1);
        do_read(3, 1'b0);
        check("fresh_window", rd_window, 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3);
        check("fresh_valid",  128'(rd_valid), 128'd1);
        do_read(0, 1'b0);
        check("fresh_col0_model", rd_window, exp_w);
        do_read(15, 1'b0);
        check("fresh_col15", rd_window, 128'hACADAEAF_BCBDBEBF_CCCDCECF_DCDDDEDF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
